// File: rtl/memory_access_if.sv
// Data-memory req/ack bus between the memory stage (master) and the memory (slave).
// The request fields are held stable from req rising until ack or timeout.
interface memory_access_if #(
   parameter int XLEN = 32
);
   logic            dmem_req;
   logic            dmem_we;
   logic [XLEN-1:0] dmem_addr;
   logic [3:0]      dmem_be;
   logic [XLEN-1:0] dmem_wdata;
   logic [XLEN-1:0] dmem_rdata;
   logic            dmem_ack;

   modport master (
      output dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
      input  dmem_rdata, dmem_ack
   );

   modport slave (
      input  dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
      output dmem_rdata, dmem_ack
   );
endinterface

// File: rtl/memory_access.sv
// Memory stage: issues loads/stores, formats load data, registers the _mw pipeline fields.
// Aligned memops stall until ack (or timeout) plus one DONE cycle; others capture in one edge.
module memory_access #(
   parameter int XLEN        = 32,
   parameter int OPLEN       = 6,
   parameter int TIMEOUT_CYC = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_phase_memory,
   input  logic [OPLEN-1:0] i_decoded_op_em,
   input  logic             i_jump_state_em,
   input  logic [4:0]       i_rdsel_em,
   input  logic [XLEN-1:0]  i_next_pc_em,
   input  logic [XLEN-1:0]  i_alu_out_em,
   input  logic [XLEN-1:0]  i_csr_out_em,
   input  logic [XLEN-1:0]  i_rs2data_em,
   input  logic             i_mem_read_em,
   input  logic             i_mem_write_em,
   input  logic [2:0]       i_mem_funct3_em,
   memory_access_if.master  dmem,
   output logic [OPLEN-1:0] o_decoded_op_mw,
   output logic             o_jump_state_mw,
   output logic [4:0]       o_rdsel_mw,
   output logic [XLEN-1:0]  o_next_pc_mw,
   output logic [XLEN-1:0]  o_alu_out_mw,
   output logic [XLEN-1:0]  o_csr_out_mw,
   output logic [XLEN-1:0]  o_mem_out_mw,
   output logic             o_misaligned_mw,
   output logic             o_bus_error_mw,
   output logic             o_stall_memory
);
   localparam int CW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYC - 1);

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;
   state_t r_state, w_next;

   logic [CW-1:0]    r_cnt;
   logic             r_req, r_we, r_load;
   logic [XLEN-1:0]  r_addr, r_wdata;
   logic [3:0]       r_be;
   logic [1:0]       r_lane;
   logic [2:0]       r_f3;
   logic [OPLEN-1:0] r_decoded_op;
   logic             r_jump, r_mis, r_berr;
   logic [4:0]       r_rdsel;
   logic [XLEN-1:0]  r_next_pc, r_alu_out, r_csr_out, r_mem_out;

   logic            w_memop, w_misaligned, w_issue, w_bypass, w_ack, w_tmo;
   logic [1:0]      w_lane;
   logic [3:0]      w_be;
   logic [XLEN-1:0] w_wdata, w_shifted, w_load;

   assign w_memop = i_mem_read_em | i_mem_write_em;
   assign w_lane  = i_alu_out_em[1:0];

   // Unsigned sizes (100/101) exist only for loads.
   always_comb begin
      w_misaligned = 1'b1;
      case (i_mem_funct3_em)
         3'b000:  w_misaligned = 1'b0;
         3'b001:  w_misaligned = w_lane[0];
         3'b010:  w_misaligned = |w_lane;
         3'b100:  w_misaligned = ~i_mem_read_em;
         3'b101:  w_misaligned = ~i_mem_read_em | w_lane[0];
         default: w_misaligned = 1'b1;
      endcase
   end

   assign w_issue  = (r_state == S_IDLE) & i_phase_memory & w_memop & ~w_misaligned;
   assign w_bypass = (r_state == S_IDLE) & i_phase_memory & ~(w_memop & ~w_misaligned);
   assign w_ack    = (r_state == S_WAIT) & dmem.dmem_ack;
   assign w_tmo    = (r_state == S_WAIT) & ~dmem.dmem_ack & (r_cnt == CNT_LAST);

   always_ff @(posedge clk) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_next;
   end

   always_comb begin
      w_next         = r_state;
      o_stall_memory = 1'b0;
      case (r_state)
         S_IDLE:  if (w_issue) w_next = S_WAIT;
         S_WAIT:  if (w_ack || w_tmo) w_next = S_DONE;
         S_DONE:  w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
      if (r_state != S_DONE)
         o_stall_memory = i_phase_memory & w_memop & ~w_misaligned;
   end

   always_comb begin
      w_be    = 4'b1111;
      w_wdata = i_rs2data_em;
      case (i_mem_funct3_em[1:0])
         2'b00: begin
            w_be    = 4'b0001 << w_lane;
            w_wdata = {4{i_rs2data_em[7:0]}};
         end
         2'b01: begin
            w_be    = 4'b0011 << w_lane;
            w_wdata = {2{i_rs2data_em[15:0]}};
         end
         default: ;
      endcase
   end

   assign w_shifted = dmem.dmem_rdata >> {r_lane, 3'b000};

   always_comb begin
      w_load = dmem.dmem_rdata;
      case (r_f3[1:0])
         2'b00: w_load = r_f3[2] ? {{(XLEN-8){1'b0}}, w_shifted[7:0]}
                                 : {{(XLEN-8){w_shifted[7]}}, w_shifted[7:0]};
         2'b01: w_load = r_f3[2] ? {{(XLEN-16){1'b0}}, w_shifted[15:0]}
                                 : {{(XLEN-16){w_shifted[15]}}, w_shifted[15:0]};
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_cnt <= '0; r_req <= 1'b0; r_we <= 1'b0; r_load <= 1'b0;
         r_addr <= '0; r_wdata <= '0; r_be <= '0; r_lane <= '0; r_f3 <= '0;
         r_decoded_op <= '0; r_jump <= 1'b0; r_rdsel <= '0; r_next_pc <= '0;
         r_alu_out <= '0; r_csr_out <= '0; r_mem_out <= '0; r_mis <= 1'b0; r_berr <= 1'b0;
      end else begin
         if (w_issue)                 r_cnt <= '0;
         else if (r_state == S_WAIT)  r_cnt <= r_cnt + 1'b1;

         if (w_issue) begin
            r_req   <= 1'b1;
            r_we    <= i_mem_write_em;
            r_addr  <= {i_alu_out_em[XLEN-1:2], 2'b00};
            r_be    <= w_be;
            r_wdata <= w_wdata;
            r_lane  <= w_lane;
            r_f3    <= i_mem_funct3_em;
            r_load  <= i_mem_read_em;
         end else if (w_ack || w_tmo) begin
            r_req <= 1'b0;
            r_we  <= 1'b0;
         end

         // Faulted accesses zero rdsel so writeback never touches the register file.
         if (w_bypass || w_ack || w_tmo) begin
            r_decoded_op <= i_decoded_op_em;
            r_jump       <= i_jump_state_em;
            r_next_pc    <= i_next_pc_em;
            r_alu_out    <= i_alu_out_em;
            r_csr_out    <= i_csr_out_em;
            r_mis        <= w_bypass & w_memop;
            r_berr       <= w_tmo;
            r_rdsel      <= ((w_bypass & w_memop) | w_tmo) ? 5'd0 : i_rdsel_em;
            r_mem_out    <= (w_ack & r_load) ? w_load : '0;
         end
      end
   end

   assign dmem.dmem_req   = r_req;
   assign dmem.dmem_we    = r_we;
   assign dmem.dmem_addr  = r_addr;
   assign dmem.dmem_be    = r_be;
   assign dmem.dmem_wdata = r_wdata;

   assign o_decoded_op_mw = r_decoded_op;
   assign o_jump_state_mw = r_jump;
   assign o_rdsel_mw      = r_rdsel;
   assign o_next_pc_mw    = r_next_pc;
   assign o_alu_out_mw    = r_alu_out;
   assign o_csr_out_mw    = r_csr_out;
   assign o_mem_out_mw    = r_mem_out;
   assign o_misaligned_mw = r_mis;
   assign o_bus_error_mw  = r_berr;
endmodule

// File: tb/tb_memory_access.sv
// Scoreboard bench for memory_access: expected records are queued at issue and popped at capture.
// A bus responder inside run_op acks after a per-op number of WAIT cycles (or never).
module tb_memory_access;
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic        phase, jmp, mrd, mwr;
   logic [5:0]  dop;
   logic [4:0]  rdsel;
   logic [2:0]  f3;
   logic [31:0] npc, alu, csr, rs2;

   logic [5:0]  o_dop;
   logic        o_jmp, o_mis, o_berr, o_stall;
   logic [4:0]  o_rdsel;
   logic [31:0] o_npc, o_alu, o_csr, o_mem;

   memory_access_if #(.XLEN(32)) bus();

   memory_access #(.XLEN(32), .OPLEN(6), .TIMEOUT_CYC(16)) dut (
      .clk(clk), .rst(rst),
      .i_phase_memory(phase), .i_decoded_op_em(dop), .i_jump_state_em(jmp),
      .i_rdsel_em(rdsel), .i_next_pc_em(npc), .i_alu_out_em(alu), .i_csr_out_em(csr),
      .i_rs2data_em(rs2), .i_mem_read_em(mrd), .i_mem_write_em(mwr), .i_mem_funct3_em(f3),
      .dmem(bus.master),
      .o_decoded_op_mw(o_dop), .o_jump_state_mw(o_jmp), .o_rdsel_mw(o_rdsel),
      .o_next_pc_mw(o_npc), .o_alu_out_mw(o_alu), .o_csr_out_mw(o_csr),
      .o_mem_out_mw(o_mem), .o_misaligned_mw(o_mis), .o_bus_error_mw(o_berr),
      .o_stall_memory(o_stall)
   );

   typedef struct {
      logic [31:0] mem_out, alu, npc, csr, addr, wdata;
      logic [4:0]  rdsel;
      logic [5:0]  op;
      logic [3:0]  be;
      logic        jmp, mis, berr, we;
      int          stall_cyc, req_cyc;
   } exp_t;

   exp_t sb[$];
   int n_chk = 0;
   int n_fail = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic exp_t mk(input logic [31:0] mem_out, input logic [4:0] rd,
                               input logic mis, input logic berr, input logic [31:0] addr,
                               input logic [3:0] be, input logic [31:0] wdata, input logic we,
                               input int stall_cyc, input int req_cyc);
      exp_t e;
      e.mem_out = mem_out; e.rdsel = rd; e.mis = mis; e.berr = berr;
      e.addr = addr; e.be = be; e.wdata = wdata; e.we = we;
      e.stall_cyc = stall_cyc; e.req_cyc = req_cyc;
      e.alu = '0; e.npc = '0; e.csr = '0; e.op = '0; e.jmp = 1'b0;
      return e;
   endfunction

   task automatic run_op(input string nm, input logic rd, input logic wr, input logic [2:0] fn,
                         input logic [4:0] rds, input logic [31:0] addr, input logic [31:0] sdata,
                         input logic [31:0] rdat, input int ack_dly, input exp_t e_in);
      exp_t e, g;
      int stall_c = 0;
      int req_c = 0;
      bit done = 0;
      e = e_in;
      @(negedge clk);
      mrd = rd; mwr = wr; f3 = fn; rdsel = rds; alu = addr; rs2 = sdata;
      npc = addr ^ 32'h0F0F_0000; csr = ~addr; dop = addr[5:0]; jmp = addr[0];
      e.alu = addr; e.npc = npc; e.csr = csr; e.op = dop; e.jmp = jmp;
      sb.push_back(e);
      phase = 1'b1;
      for (int c = 0; c < 40 && !done; c++) begin
         #1;
         bus.dmem_ack = 1'b0;
         bus.dmem_rdata = $urandom;
         if (bus.dmem_req) begin
            if (req_c == 0) begin
               chk($sformatf("%s.addr", nm), bus.dmem_addr, e.addr);
               chk($sformatf("%s.we", nm), 32'(bus.dmem_we), 32'(e.we));
               if (wr) begin
                  chk($sformatf("%s.be", nm), 32'(bus.dmem_be), 32'(e.be));
                  chk($sformatf("%s.wdata", nm), bus.dmem_wdata, e.wdata);
               end
            end
            if (req_c == ack_dly) begin
               bus.dmem_ack = 1'b1;
               bus.dmem_rdata = rdat;
            end
            req_c++;
         end
         if (o_stall) stall_c++;
         else done = 1;
         if (!done) @(negedge clk);
      end
      if (!done) chk($sformatf("%s.bound", nm), 32'd0, 32'd1);
      @(posedge clk);
      #1;
      bus.dmem_ack = 1'b0;
      phase = 1'b0;
      g = sb.pop_front();
      chk($sformatf("%s.mem_out", nm), o_mem, g.mem_out);
      chk($sformatf("%s.rdsel", nm), 32'(o_rdsel), 32'(g.rdsel));
      chk($sformatf("%s.alu", nm), o_alu, g.alu);
      chk($sformatf("%s.npc", nm), o_npc, g.npc);
      chk($sformatf("%s.csr", nm), o_csr, g.csr);
      chk($sformatf("%s.op", nm), 32'(o_dop), 32'(g.op));
      chk($sformatf("%s.jmp", nm), 32'(o_jmp), 32'(g.jmp));
      chk($sformatf("%s.mis", nm), 32'(o_mis), 32'(g.mis));
      chk($sformatf("%s.berr", nm), 32'(o_berr), 32'(g.berr));
      chk($sformatf("%s.stall_cyc", nm), 32'(stall_c), 32'(g.stall_cyc));
      chk($sformatf("%s.req_cyc", nm), 32'(req_c), 32'(g.req_cyc));
      chk($sformatf("%s.req_off", nm), 32'(bus.dmem_req), 32'd0);
   endtask

   initial begin
      bit seen;
      rst = 1'b1; phase = 1'b0; mrd = 1'b0; mwr = 1'b0; f3 = '0; rdsel = '0;
      alu = '0; rs2 = '0; npc = '0; csr = '0; dop = '0; jmp = 1'b0;
      bus.dmem_ack = 1'b0; bus.dmem_rdata = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst.req", 32'(bus.dmem_req), 32'd0);
      chk("rst.mem_out", o_mem, 32'd0);
      chk("rst.rdsel", 32'(o_rdsel), 32'd0);
      chk("rst.stall", 32'(o_stall), 32'd0);
      chk("rst.mis", 32'(o_mis), 32'd0);
      @(negedge clk);
      rst = 1'b0;

      //       name     rd wr f3      rd  addr          sdata         rdata         dly
      run_op("alu",    0, 0, 3'b000, 5,  32'h0000_1234, 32'h0,        32'h0,        -1,
             mk(32'h0, 5, 0, 0, 32'h0, 4'h0, 32'h0, 0, 0, 0));
      run_op("lb",     1, 0, 3'b000, 7,  32'h0000_0103, 32'h0,        32'h80FF_FF11, 0,
             mk(32'hFFFF_FF80, 7, 0, 0, 32'h0000_0100, 4'h0, 32'h0, 0, 2, 1));
      run_op("lhu",    1, 0, 3'b101, 8,  32'h0000_0102, 32'h0,        32'h8001_0000, 0,
             mk(32'h0000_8001, 8, 0, 0, 32'h0000_0100, 4'h0, 32'h0, 0, 2, 1));
      run_op("lw_mis", 1, 0, 3'b010, 9,  32'h0000_0102, 32'h0,        32'h0,        0,
             mk(32'h0, 0, 1, 0, 32'h0, 4'h0, 32'h0, 0, 0, 0));
      run_op("sb",     0, 1, 3'b000, 0,  32'h0000_0201, 32'h0000_00AB, 32'h0,       1,
             mk(32'h0, 0, 0, 0, 32'h0000_0200, 4'b0010, 32'hABAB_ABAB, 1, 3, 2));
      run_op("sh",     0, 1, 3'b001, 0,  32'h0000_0202, 32'h0000_1234, 32'h0,       0,
             mk(32'h0, 0, 0, 0, 32'h0000_0200, 4'b1100, 32'h1234_1234, 1, 2, 1));
      run_op("lh",     1, 0, 3'b001, 10, 32'h0000_0102, 32'h0,        32'h8001_0000, 3,
             mk(32'hFFFF_8001, 10, 0, 0, 32'h0000_0100, 4'h0, 32'h0, 0, 5, 4));
      run_op("lw",     1, 0, 3'b010, 11, 32'h0000_0100, 32'h0,        32'hDEAD_BEEF, 0,
             mk(32'hDEAD_BEEF, 11, 0, 0, 32'h0000_0100, 4'h0, 32'h0, 0, 2, 1));
      run_op("tmo",    1, 0, 3'b100, 13, 32'h0000_0104, 32'h0,        32'h0,        -1,
             mk(32'h0, 0, 0, 1, 32'h0000_0104, 4'h0, 32'h0, 0, 17, 16));
      run_op("lbu",    1, 0, 3'b100, 12, 32'h0000_0105, 32'h0,        32'h0000_F000, 0,
             mk(32'h0000_00F0, 12, 0, 0, 32'h0000_0104, 4'h0, 32'h0, 0, 2, 1));
      run_op("st_bad", 0, 1, 3'b100, 0,  32'h0000_0300, 32'h1111_2222, 32'h0,       0,
             mk(32'h0, 0, 1, 0, 32'h0, 4'h0, 32'h0, 0, 0, 0));
      run_op("sw",     0, 1, 3'b010, 0,  32'h0000_0300, 32'hCAFE_F00D, 32'h0,       2,
             mk(32'h0, 0, 0, 0, 32'h0000_0300, 4'b1111, 32'hCAFE_F00D, 1, 4, 3));
      run_op("lb_pos", 1, 0, 3'b000, 14, 32'h0000_0101, 32'h0,        32'h0000_7F00, 0,
             mk(32'h0000_007F, 14, 0, 0, 32'h0000_0100, 4'h0, 32'h0, 0, 2, 1));

      // Stray ack while idle must not start or complete anything.
      @(negedge clk);
      bus.dmem_ack = 1'b1; bus.dmem_rdata = 32'h5555_5555;
      repeat (2) @(posedge clk);
      #1;
      chk("idle_ack.req", 32'(bus.dmem_req), 32'd0);
      chk("idle_ack.mem_out", o_mem, 32'h0000_007F);
      bus.dmem_ack = 1'b0;

      // Reset arriving in WAIT together with an ack.
      @(negedge clk);
      mrd = 1'b1; mwr = 1'b0; f3 = 3'b010; alu = 32'h0000_0400; rdsel = 5'd6;
      phase = 1'b1;
      seen = 0;
      for (int c = 0; c < 6 && !seen; c++) begin
         #1;
         if (bus.dmem_req) seen = 1;
         else @(negedge clk);
      end
      chk("rstw.req_seen", 32'(seen), 32'd1);
      bus.dmem_ack = 1'b1; bus.dmem_rdata = 32'h1234_5678; rst = 1'b1;
      @(posedge clk);
      #1;
      chk("rstw.req", 32'(bus.dmem_req), 32'd0);
      chk("rstw.mem_out", o_mem, 32'd0);
      chk("rstw.rdsel", 32'(o_rdsel), 32'd0);
      chk("rstw.alu", o_alu, 32'd0);
      chk("rstw.npc", o_npc, 32'd0);
      chk("rstw.mis_berr", 32'({o_mis, o_berr}), 32'd0);
      rst = 1'b0; phase = 1'b0; bus.dmem_ack = 1'b0; mrd = 1'b0;
      @(negedge clk);
      #1;
      chk("rstw.idle_req", 32'(bus.dmem_req), 32'd0);
      run_op("alu2",   0, 0, 3'b000, 3,  32'h0000_BEEF, 32'h0,        32'h0,        -1,
             mk(32'h0, 3, 0, 0, 32'h0, 4'h0, 32'h0, 0, 0, 0));

      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/memory_access.md
Name: memory_access

Overview:
- Memory stage of the core: sits between execute and writeback, drives every `*_mw` input that writeback consumes.
- Performs data-memory loads/stores over a req/ack bus, formats load data (byte lane select, sign/zero extend), and registers pass-through pipeline fields.
- Raises `stall_memory` to the StateMachine while a bus transaction is outstanding.

Parameters:
- XLEN, 32, data/address width (core supports 32 only).
- OPLEN, from core_general.vh, decoded opcode bus width (pass-through only).
- TIMEOUT_CYC, 16, WAIT cycles without ack before bus error (≥2).

Ports:
- clk  input  1  core clock.
- rst  input  1  synchronous active-high reset.
- phase_memory  input  1  memory phase active (StateMachine).
- decoded_op_em  input  OPLEN  decoded opcode from execute.
- jump_state_em  input  1  next PC is jump address.
- rdsel_em  input  5  RD select.
- next_pc_em  input  XLEN  next PC.
- alu_out_em  input  XLEN  ALU result; also load/store address.
- csr_out_em  input  XLEN  CSR read data.
- rs2data_em  input  XLEN  store data.
- mem_read_em  input  1  load instruction.
- mem_write_em  input  1  store instruction (never both set).
- mem_funct3_em  input  3  RV32 size/sign funct3.
- dmem_req  output  1  bus request.
- dmem_we  output  1  write enable.
- dmem_addr  output  XLEN  word-aligned address ({alu_out[31:2],2'b00}).
- dmem_be  output  4  byte enables.
- dmem_wdata  output  XLEN  lane-aligned write data.
- dmem_rdata  input  XLEN  read data, valid with ack.
- dmem_ack  input  1  transaction done.
- decoded_op_mw, jump_state_mw, rdsel_mw, next_pc_mw, alu_out_mw, csr_out_mw  output  as inputs  registered pass-throughs.
- mem_out_mw  output  XLEN  formatted load data.
- misaligned_mw  output  1  misaligned/illegal-size access flag.
- bus_error_mw  output  1  bus timeout flag.
- stall_memory  output  1  stall memory phase.

Behaviour:
- Reset: all outputs 0, state IDLE, timeout counter 0. Reset mid-WAIT drops `dmem_req` at the next edge; no `_mw` update occurs.
- memop = mem_read_em | mem_write_em.
- Legal funct3 and alignment:
  - load: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - store: 000 SB, 001 SH, 010 SW.
  - misaligned: halfword with addr[0]=1; word with addr[1:0]≠0; or any other funct3.
- `stall_memory` is combinational: phase_memory & memop & ~misaligned & (state≠DONE).
- States and transitions:
  - IDLE, phase_memory & ~memop: registers capture at the edge; no stall.
  - IDLE, phase_memory & memop & misaligned: no bus request. Capture with misaligned_mw=1, mem_out_mw=0, rdsel_mw=0 (suppresses RD write).
  - IDLE, phase_memory & memop & aligned: → WAIT; dmem_req/we/addr/be/wdata registered at this edge.
  - WAIT: bus outputs held stable. Counter increments each cycle.
    - dmem_ack: capture formatted rdata (load) or 0 (store) into mem_out_mw, capture pass-throughs, deassert req, → DONE.
    - Counter reaches TIMEOUT_CYC-1 with no ack: deassert req, bus_error_mw=1, mem_out_mw=0, rdsel_mw=0, → DONE.
  - DONE: stall low for one cycle so the StateMachine advances; → IDLE at next edge.
- `_mw` outputs hold between captures. misaligned_mw and bus_error_mw are cleared at the next capture.
- `dmem_ack` is ignored outside WAIT.
- Store lanes, with a = addr[1:0]:
  - SB: wdata = byte replicated ×4, be = 4'b0001<<a.
  - SH: wdata = half replicated ×2, be = 4'b0011<<a.
  - SW: be = 4'b1111.
- Load format: select lane rdata[8a+:8] (byte) or rdata[8a+:16] (half); sign-extend for LB/LH, zero-extend for LBU/LHU.
- Latency: load issued in cycle N with ack in N+1 → stall high N, N+1; mem_out_mw valid from N+2.

Test Plan:
- ALU op, alu_out_em=0x1234, rdsel_em=5, no memop → stall never high; alu_out_mw=0x1234, rdsel_mw=5 one edge later.
- LB addr 0x103, rdata=0x80FF_FF11, ack in first WAIT cycle → dmem_addr=0x100; mem_out_mw=0xFFFF_FF80; stall 2 cycles.
- LHU addr 0x102, rdata=0x8001_0000 → mem_out_mw=0x0000_8001. LW addr 0x102 → misaligned_mw=1, no dmem_req, rdsel_mw=0.
- SB addr 0x201 data 0xAB → dmem_be=0010, dmem_wdata=0xABAB_ABAB, dmem_we=1. SH addr 0x202 data 0x1234 → be=1100, wdata=0x1234_1234.
- Load with no ack → req drops after 16 WAIT cycles; bus_error_mw=1, rdsel_mw=0, stall released.
- rst asserted in WAIT with an ack in the same cycle → next edge: req=0, state IDLE, all `_mw` outputs 0.
